// File: rtl/squared_distance_accumulator.sv
// Sums FEATURE_COUNT consecutive squared differences into one squared Euclidean distance per vector.
// Optional saturating arithmetic and overflow flag when SQUARED_DISTANCE_SATURATE_EN is defined.
module squared_distance_accumulator #(
    parameter int SQUARE_WIDTH  = 22,
    parameter int FEATURE_COUNT = 6,
    parameter int SUM_WIDTH     = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SQUARE_WIDTH-1:0] square,
    input  logic                    new_result,
    input  logic                    flush,
    output logic [SUM_WIDTH-1:0]    distance,
    output logic                    distance_valid,
`ifdef SQUARED_DISTANCE_SATURATE_EN
    output logic                    overflow,
`endif
    output logic                    busy
);

    localparam int INDEX_W = $clog2(FEATURE_COUNT);
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(FEATURE_COUNT - 1);

    logic [SUM_WIDTH-1:0] acc_p0;
    logic [INDEX_W-1:0]   index_p0;
    logic [SUM_WIDTH-1:0] square_ext;
    logic [SUM_WIDTH-1:0] sum_next;
    logic                 accept;
    logic                 last;

    assign square_ext = SUM_WIDTH'(square);
    assign accept     = new_result && !flush;
    assign last       = (index_p0 == LAST_INDEX);
    assign busy       = (index_p0 != '0);

`ifdef SQUARED_DISTANCE_SATURATE_EN
    logic add_sat;
    logic sat_seen_p0;

    // Clamp to all-ones on carry out; MSB of the result reports the clamp.
    function automatic logic [SUM_WIDTH:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [SUM_WIDTH-1:0] b);
        logic [SUM_WIDTH:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        if (wide[SUM_WIDTH])
            return {1'b1, {SUM_WIDTH{1'b1}}};
        return wide;
    endfunction

    assign {add_sat, sum_next} = sat_add(acc_p0, square_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_seen_p0 <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (flush) begin
                sat_seen_p0 <= 1'b0;
            end else if (new_result) begin
                if (last) begin
                    overflow    <= sat_seen_p0 | add_sat;
                    sat_seen_p0 <= 1'b0;
                end else begin
                    sat_seen_p0 <= sat_seen_p0 | add_sat;
                end
            end
        end
    end
`else
    assign sum_next = acc_p0 + square_ext;
`endif

    // ---- accumulate stage -> registered distance output ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_p0         <= '0;
            index_p0       <= '0;
            distance       <= '0;
            distance_valid <= 1'b0;
        end else begin
            distance_valid <= 1'b0;
            if (flush) begin
                acc_p0   <= '0;
                index_p0 <= '0;
            end else if (accept) begin
                if (last) begin
                    distance       <= sum_next;
                    distance_valid <= 1'b1;
                    acc_p0         <= '0;
                    index_p0       <= '0;
                end else begin
                    acc_p0   <= sum_next;
                    index_p0 <= index_p0 + INDEX_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/squared_distance_accumulator.md
Name: squared_distance_accumulator

Overview:
- Downstream of the squaring stage in the SVM RBF kernel datapath.
- Consumes one squared feature difference per valid cycle and sums FEATURE_COUNT consecutive squares into one squared Euclidean distance per vector.
- Emits the distance with a one-cycle valid pulse to the exponential/kernel stage.
- Supports back-to-back vectors with no bubble.

Parameters:
- SQUARE_WIDTH, 22, width of the unsigned input square (2*(VALUE_WIDTH-1) with VALUE_WIDTH=12).
- FEATURE_COUNT, 6, squares summed per vector; must be ≥2.
- SUM_WIDTH, 25, width of the distance output; must be ≥ SQUARE_WIDTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- square  in  SQUARE_WIDTH  unsigned squared difference from the squaring stage.
- new_result  in  1  square is valid this cycle.
- flush  in  1  synchronous abort of the partial vector.
- distance  out  SUM_WIDTH  registered sum of FEATURE_COUNT squares.
- distance_valid  out  1  one-cycle pulse; distance is valid.
- busy  out  1  high while a partial vector is held (index ≠ 0).

Behaviour:
- Reset (reset=0, asynchronous): distance=0, distance_valid=0, busy=0, accumulator=0, index=0, state IDLE.
- State: index counter 0..FEATURE_COUNT-1 and accumulator acc[SUM_WIDTH-1:0]. IDLE ≡ index==0; ACCUM ≡ index>0.
- busy is combinational from index≠0.
- square is zero-extended to SUM_WIDTH before every add.
- Cycle with new_result=1, flush=0, index<FEATURE_COUNT-1: acc ← acc+square; index ← index+1.
- Cycle with new_result=1, flush=0, index==FEATURE_COUNT-1:
  - distance ← acc+square; distance_valid ← 1.
  - acc ← 0; index ← 0.
  - The next cycle may start a new vector, so the sustained rate is one vector per FEATURE_COUNT cycles.
- Cycle with new_result=0: acc and index hold; distance_valid ← 0. distance holds its last value.
- Latency: distance_valid rises 1 cycle after the clock edge that accepts the last square.
- flush=1 (priority over new_result): acc ← 0; index ← 0; distance_valid ← 0. The square presented that cycle is discarded and distance holds.
- flush during IDLE: no effect.
- Arithmetic without the optional feature: the add wraps modulo 2^SUM_WIDTH. With defaults, 6*(2^22-1) < 2^25, so no wrap is possible.
- Reset asserted mid-vector: the partial sum is lost and, after release, the next valid square is element 0.
- distance_valid is never asserted two cycles in a row.

Optional Feature:
- Macro: SQUARED_DISTANCE_SATURATE_EN.
- Defined:
  - Every add saturates at 2^SUM_WIDTH-1.
  - An extra output, overflow (1 bit), is registered alongside distance and pulses with distance_valid when any add in that vector saturated.
  - The sticky per-vector flag clears on vector completion, flush and reset.
  - Intended for SUM_WIDTH < SQUARE_WIDTH+clog2(FEATURE_COUNT).
- Undefined: wrapping add, and no overflow port exists.

Test Plan:
- Reset held 2 cycles, then squares 1,4,9,16,25,36 on consecutive valid cycles -> distance=91 and distance_valid=1 exactly 1 cycle after the 6th square; busy high from cycle after 1st square until the 6th is accepted.
- Two back-to-back vectors of 2250000 each (12 consecutive valid cycles) -> distance=13500000 pulsed twice, 6 cycles apart, with no gap in acceptance.
- Squares 10,20,30 with new_result low for 3 cycles between each, then 40,50,60 -> single distance=210; no pulse during gaps; busy stays high through gaps.
- Squares 5,5,5, then flush=1 together with new_result=1 and square 5, then 1,2,3,4,5,6 -> only pulse is distance=21; the flushed square is not counted.
- reset pulled low asynchronously mid-cycle after 4 squares -> all outputs 0 immediately; after release, 7,7,7,7,7,7 -> distance=42.
- With SQUARED_DISTANCE_SATURATE_EN and SUM_WIDTH=22: six squares of 4194303 -> distance=4194303 and overflow=1; the next vector of six 1s -> distance=6 and overflow=0.
